// File: rtl/bus_arbiter.sv
// Zorro II DMA bus-ownership arbiter: hands the mainboard bus from the accelerator CPU to a DMA master via BR/BG/BGACK.
// Latency: SYNC_STAGES+1 edges from any async input to registered outputs; a DMA master stalls in GRANT until BGACK or timeout.
module bus_arbiter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = 16,
  parameter int TURNAROUND    = 2
) (
  input  logic C7M,
  input  logic RESET,
  input  logic BR_MB_n,
  input  logic BGACK_MB_n,
  input  logic BG_CPU_n,
  input  logic AS_CPU_n,
  output logic BR_CPU_n,
  output logic BGACK_CPU_n,
  output logic BG_MB_n,
  output logic BUS_DRIVE_EN,
  output logic DMA_ACTIVE,
  output logic TIMEOUT_PULSE
);

  typedef enum logic [2:0] {
    CPU_OWN,
    REQ,
    DRV_OFF,
    GRANT,
    DMA,
    TURN
  } state_t;

  localparam logic [7:0] GT_LAST = 8'(GRANT_TIMEOUT - 1);
  localparam logic [3:0] TA_LAST = 4'(TURNAROUND - 1);

  logic [SYNC_STAGES-1:0] br_sync_q, bgack_sync_q, bg_sync_q, as_sync_q;
  logic                   br_s, bgack_s, bg_s, as_s;

  state_t     state_q, state_d;
  logic [7:0] grant_cnt_q, grant_cnt_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;
  logic       pulse_d;

  // Synchronizers idle high so reset looks like every line deasserted.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      br_sync_q    <= '1;
      bgack_sync_q <= '1;
      bg_sync_q    <= '1;
      as_sync_q    <= '1;
    end else begin
      br_sync_q    <= {br_sync_q[SYNC_STAGES-2:0], BR_MB_n};
      bgack_sync_q <= {bgack_sync_q[SYNC_STAGES-2:0], BGACK_MB_n};
      bg_sync_q    <= {bg_sync_q[SYNC_STAGES-2:0], BG_CPU_n};
      as_sync_q    <= {as_sync_q[SYNC_STAGES-2:0], AS_CPU_n};
    end
  end

  assign br_s    = ~br_sync_q[SYNC_STAGES-1];
  assign bgack_s = ~bgack_sync_q[SYNC_STAGES-1];
  assign bg_s    = ~bg_sync_q[SYNC_STAGES-1];
  assign as_s    = ~as_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    grant_cnt_d = grant_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    pulse_d     = 1'b0;
    case (state_q)
      CPU_OWN: begin
        // BGACK without our grant: a master already owns the bus, get off it now.
        if (bgack_s)   state_d = DMA;
        else if (br_s) state_d = REQ;
      end
      REQ: begin
        if (!br_s)             state_d = CPU_OWN;
        else if (bg_s && !as_s) state_d = DRV_OFF;
      end
      DRV_OFF: begin
        state_d     = GRANT;
        grant_cnt_d = 8'd0;
      end
      GRANT: begin
        if (bgack_s) begin
          state_d = DMA;
        end else if (!br_s) begin
          state_d    = TURN;
          turn_cnt_d = 4'd0;
        end else if (grant_cnt_q == GT_LAST) begin
          state_d    = TURN;
          turn_cnt_d = 4'd0;
          pulse_d    = 1'b1;
        end else if (grant_cnt_q != 8'hFF) begin
          grant_cnt_d = grant_cnt_q + 8'd1;
        end
      end
      DMA: begin
        if (!bgack_s) begin
          state_d    = TURN;
          turn_cnt_d = 4'd0;
        end
      end
      TURN: begin
        if (turn_cnt_q == TA_LAST) state_d = CPU_OWN;
        else                        turn_cnt_d = turn_cnt_q + 4'd1;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      state_q       <= CPU_OWN;
      grant_cnt_q   <= 8'd0;
      turn_cnt_q    <= 4'd0;
      BR_CPU_n      <= 1'b1;
      BGACK_CPU_n   <= 1'b1;
      BG_MB_n       <= 1'b1;
      BUS_DRIVE_EN  <= 1'b1;
      DMA_ACTIVE    <= 1'b0;
      TIMEOUT_PULSE <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_cnt_q   <= grant_cnt_d;
      turn_cnt_q    <= turn_cnt_d;
      BR_CPU_n      <= !(state_d inside {REQ, DRV_OFF, GRANT});
      BGACK_CPU_n   <= (state_d != DMA);
      BG_MB_n       <= (state_d != GRANT);
      BUS_DRIVE_EN  <= (state_d inside {CPU_OWN, REQ});
      DMA_ACTIVE    <= (state_d == DMA);
      TIMEOUT_PULSE <= pulse_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed handshake scenarios then random line activity, every cycle checked against a reference model.
module tb_bus_arbiter;

  localparam int SYNC = 2;
  localparam int GTO  = 16;
  localparam int TA   = 2;

  localparam int M_OWN = 0, M_REQ = 1, M_DRV = 2, M_GNT = 3, M_DMA = 4, M_TRN = 5;

  logic clk = 1'b0;
  logic rst, br_n, bgack_n, bg_n, as_n;
  logic br_cpu_n, bgack_cpu_n, bg_mb_n, drive_en, dma_active, to_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  int mode, timer;
  bit pulse;
  bit q_br[$], q_bgack[$], q_bg[$], q_as[$];

  always #5 clk = ~clk;

  bus_arbiter #(.SYNC_STAGES(SYNC), .GRANT_TIMEOUT(GTO), .TURNAROUND(TA)) dut (
    .C7M(clk), .RESET(rst),
    .BR_MB_n(br_n), .BGACK_MB_n(bgack_n), .BG_CPU_n(bg_n), .AS_CPU_n(as_n),
    .BR_CPU_n(br_cpu_n), .BGACK_CPU_n(bgack_cpu_n), .BG_MB_n(bg_mb_n),
    .BUS_DRIVE_EN(drive_en), .DMA_ACTIVE(dma_active), .TIMEOUT_PULSE(to_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_br = {}; q_bgack = {}; q_bg = {}; q_as = {};
    for (int i = 0; i < SYNC; i++) begin
      q_br.push_back(1'b1); q_bgack.push_back(1'b1);
      q_bg.push_back(1'b1); q_as.push_back(1'b1);
    end
    mode = M_OWN; timer = 0; pulse = 1'b0;
  endtask

  // Each line is seen by the controller SYNC edges after it was sampled.
  task automatic model_step();
    bit brs, bgks, bgs, ass;
    if (rst) begin
      model_reset();
      return;
    end
    brs  = !q_br.pop_front();    q_br.push_back(br_n);
    bgks = !q_bgack.pop_front(); q_bgack.push_back(bgack_n);
    bgs  = !q_bg.pop_front();    q_bg.push_back(bg_n);
    ass  = !q_as.pop_front();    q_as.push_back(as_n);
    pulse = 1'b0;
    case (mode)
      M_OWN: if (bgks) mode = M_DMA; else if (brs) mode = M_REQ;
      M_REQ: if (!brs) mode = M_OWN; else if (bgs && !ass) mode = M_DRV;
      M_DRV: begin mode = M_GNT; timer = GTO; end
      M_GNT: begin
        if (bgks) mode = M_DMA;
        else if (!brs) begin mode = M_TRN; timer = TA; end
        else begin
          timer--;
          if (timer == 0) begin mode = M_TRN; timer = TA; pulse = 1'b1; end
        end
      end
      M_DMA: if (!bgks) begin mode = M_TRN; timer = TA; end
      default: begin timer--; if (timer == 0) mode = M_OWN; end
    endcase
  endtask

  task automatic check_model();
    check("br_cpu_n",      br_cpu_n,    (mode == M_REQ || mode == M_DRV || mode == M_GNT) ? 0 : 1);
    check("bgack_cpu_n",   bgack_cpu_n, (mode == M_DMA) ? 0 : 1);
    check("bg_mb_n",       bg_mb_n,     (mode == M_GNT) ? 0 : 1);
    check("bus_drive_en",  drive_en,    (mode == M_OWN || mode == M_REQ) ? 1 : 0);
    check("dma_active",    dma_active,  (mode == M_DMA) ? 1 : 0);
    check("timeout_pulse", to_pulse,    pulse ? 1 : 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_step();
      check_model();
    end
  endtask

  initial begin
    int fell, pul;
    model_reset();
    rst = 1'b1; br_n = 1'b1; bgack_n = 1'b1; bg_n = 1'b1; as_n = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    check("idle_drive_en", drive_en, 1);
    check("idle_bg_mb_n", bg_mb_n, 1);

    // Normal DMA handshake.
    br_n = 1'b0;
    cyc(2);
    check("br_cpu_before_edge3", br_cpu_n, 1);
    cyc(1);
    check("br_cpu_at_edge3", br_cpu_n, 0);
    bg_n = 1'b0;
    cyc(3);
    check("drv_off_first", drive_en, 0);
    check("grant_after_drv_off", bg_mb_n, 1);
    cyc(1);
    check("grant_low", bg_mb_n, 0);
    cyc(3);
    bgack_n = 1'b0; br_n = 1'b1;
    cyc(3);
    check("dma_active", dma_active, 1);
    cyc(4);
    bgack_n = 1'b1; bg_n = 1'b1;
    cyc(SYNC + TA);
    check("turnaround_still_off", drive_en, 0);
    cyc(1);
    check("turnaround_drive_back", drive_en, 1);
    cyc(3);

    // Grant while the CPU still runs a cycle.
    br_n = 1'b0; as_n = 1'b0;
    cyc(3);
    bg_n = 1'b0;
    cyc(5);
    check("as_busy_drive_on", drive_en, 1);
    as_n = 1'b1;
    cyc(2);
    check("as_rise_plus2", drive_en, 1);
    cyc(1);
    check("as_rise_plus3", drive_en, 0);
    cyc(2);
    bgack_n = 1'b0; br_n = 1'b1;
    cyc(5);
    bgack_n = 1'b1; bg_n = 1'b1;
    cyc(8);

    // Grant never acknowledged: timeout.
    br_n = 1'b0; bg_n = 1'b0;
    fell = -1; pul = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (fell < 0 && bg_mb_n === 1'b0) fell = i;
      if (pul < 0 && to_pulse === 1'b1) pul = i;
    end
    check("timeout_gap", pul - fell, GTO);
    br_n = 1'b1; bg_n = 1'b1;
    cyc(30);

    // Short request withdrawn before the CPU grants.
    br_n = 1'b0;
    cyc(3);
    br_n = 1'b1;
    cyc(8);
    check("withdraw_br_cpu", br_cpu_n, 1);
    check("withdraw_drive", drive_en, 1);

    // Reset in the middle of a DMA, BGACK left asserted.
    br_n = 1'b0; bg_n = 1'b0;
    cyc(6);
    bgack_n = 1'b0; br_n = 1'b1;
    cyc(5);
    check("pre_reset_dma", dma_active, 1);
    rst = 1'b1;
    cyc(1);
    check("reset_bgack_cpu", bgack_cpu_n, 1);
    check("reset_drive_en", drive_en, 1);
    check("reset_dma_active", dma_active, 0);
    rst = 1'b0; bg_n = 1'b1;
    cyc(SYNC);
    check("violation_wait", dma_active, 0);
    cyc(1);
    check("violation_dma", dma_active, 1);
    check("violation_drive", drive_en, 0);
    bgack_n = 1'b1;
    cyc(8);

    // Random line activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) br_n    = ~br_n;
      if ($urandom_range(0, 9) == 0) bgack_n = ~bgack_n;
      if ($urandom_range(0, 4) == 0) bg_n    = ~bg_n;
      if ($urandom_range(0, 2) == 0) as_n    = ~as_n;
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
